// File: rtl/inv_sub_bytes_pkg.sv
// Shared AES constants and FSM encoding for the InvSubBytes slice.
// Holds state/byte widths and the IDLE/BUSY/DONE state type.
package inv_sub_bytes_pkg;

   localparam int STATE_W = 128;
   localparam int BYTE_W  = 8;
   localparam int NBYTES  = STATE_W / BYTE_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fsm_e;

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box, purely combinational.
// Ports: addr (byte in), dout (InvSBox(addr)).
module inv_sbox (
   input  logic [7:0] addr,
   output logic [7:0] dout
);

   // Entry x lives at bits [2047-8x -: 8]; entry 0 is the leftmost byte.
   localparam logic [2047:0] INV_TAB = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   always_comb begin
      dout = 8'h00;
      dout = INV_TAB[{~addr, 3'b000} +: 8];
   end

endmodule

// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes: BYTES_PER_CYCLE bytes per BUSY cycle.
// Ports: clk, reset (async low), valid_in/in_ready/state_in upstream,
// valid_out/out_ready/state_out downstream.
module inv_sub_bytes
   import inv_sub_bytes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               valid_in,
   output logic               in_ready,
   input  logic [STATE_W-1:0] state_in,
   output logic               valid_out,
   input  logic               out_ready,
   output logic [STATE_W-1:0] state_out
);

   localparam int NGRP = NBYTES / BYTES_PER_CYCLE;
   localparam int GW   = BYTES_PER_CYCLE * BYTE_W;
   localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [CW-1:0] LAST = CW'(NGRP - 1);

   fsm_e               r_state;
   fsm_e               w_next;
   logic [CW-1:0]      r_cnt;
   logic [STATE_W-1:0] r_work;
   logic [STATE_W-1:0] w_work_nxt;
   logic [GW-1:0]      w_grp;
   logic [GW-1:0]      w_sub;
   logic               w_last;
   logic               w_accept;

   assign w_last    = (r_cnt == LAST);
   assign w_accept  = valid_in & in_ready;
   assign state_out = r_work;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (valid_in) w_next = BUSY;
         BUSY: if (w_last) w_next = DONE;
         DONE: if (out_ready) w_next = valid_in ? BUSY : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      valid_out = 1'b0;
      unique case (r_state)
         IDLE: in_ready = 1'b1;
         DONE: begin
            in_ready  = out_ready;
            valid_out = 1'b1;
         end
         default: ;
      endcase
   end

   // Group cnt is the cnt-th GW-bit slice counting down from the MSB.
   always_comb begin
      w_grp = '0;
      for (int g = 0; g < NGRP; g++)
         if (r_cnt == CW'(g))
            w_grp = r_work[STATE_W-1-g*GW -: GW];
   end

   always_comb begin
      w_work_nxt = r_work;
      for (int g = 0; g < NGRP; g++)
         if (r_cnt == CW'(g))
            w_work_nxt[STATE_W-1-g*GW -: GW] = w_sub;
   end

   for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
      inv_sbox u_sbox (
         .addr (w_grp[GW-1-i*BYTE_W -: BYTE_W]),
         .dout (w_sub[GW-1-i*BYTE_W -: BYTE_W])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_work <= '0;
      end else if (w_accept) begin
         r_cnt  <= '0;
         r_work <= state_in;
      end else if (r_state == BUSY) begin
         r_work <= w_work_nxt;
         r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule
